// File: rtl/mmio_timer_responder_if.sv
// mmio_timer_responder_if: single-access peripheral bus between a CPU data port and a responder
// master: drives address, read_enable, write_enable, write_data; receives read_data, ready
// slave : the mirror image
interface mmio_timer_responder_if #(parameter int DATA_WIDTH = 64);
   logic [31:0]           address;
   logic                  read_enable;
   logic                  write_enable;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  ready;
   modport master (output address, read_enable, write_enable, write_data, input read_data, ready);
   modport slave  (input address, read_enable, write_enable, write_data, output read_data, ready);
endinterface

// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder: memory-mapped prescaled countdown timer with level interrupt
// Ports: clock, reset_n (async active-low), bus (slave side of the peripheral bus),
//        irq (level interrupt), capture_in (external capture strobe, only with TIMER_CAPTURE_EN)
// Map (address[5:3]): 0 CTRL {prescale[15:8], irq_en[2], auto_reload[1], enable[0]},
//        1 LOAD, 2 COUNT (ro), 3 STATUS {expired, w1c}, 4 CAPTURE (TIMER_CAPTURE_EN only)
module mmio_timer_responder #(
   parameter logic [31:0] BASE_ADDRESS = 32'h20000000,
   parameter logic [31:0] ADDRESS_MASK = 32'hFFFFFFC0,
   parameter int          DATA_WIDTH   = 64,
   parameter int          COUNT_WIDTH  = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   mmio_timer_responder_if.slave  bus,
   output logic                   irq
`ifdef TIMER_CAPTURE_EN
   ,
   input  logic                   capture_in
`endif
);
   typedef enum logic {IDLE, RESP} state_t;
   state_t                 state;
   logic                   en, ar, ien, expired;
   logic [7:0]             pre, pcnt;
   logic [COUNT_WIDTH-1:0] load, count;
   logic                   sel, acc, wr, wr_ctrl, wr_load, wr_stat, tick, fire, en_n, ien_n, exp_n;
   logic [2:0]             off;
   logic [DATA_WIDTH-1:0]  cap, rmux;
`ifdef TIMER_CAPTURE_EN
   logic [2:0]             csync;
   logic [COUNT_WIDTH-1:0] capture;
   assign cap = DATA_WIDTH'(capture);
`else
   assign cap = '0;
`endif
   always_comb begin
      sel     = (bus.read_enable | bus.write_enable) & ((bus.address & ADDRESS_MASK) == BASE_ADDRESS);
      acc     = (state == IDLE) & sel;
      wr      = acc & bus.write_enable;
      off     = bus.address[5:3];
      wr_ctrl = wr & (off == 3'd0);
      wr_load = wr & (off == 3'd1);
      wr_stat = wr & (off == 3'd3);
      tick    = en & (pcnt == pre);
      fire    = tick & (count == '0);
      // a CTRL write beats the hardware clear of enable on one-shot expiry
      en_n    = wr_ctrl ? bus.write_data[0] : (fire & ~ar) ? 1'b0 : en;
      ien_n   = wr_ctrl ? bus.write_data[2] : ien;
      // a set on the same edge beats the write-1-to-clear
      exp_n   = fire | (expired & ~(wr_stat & bus.write_data[0]));
      rmux    = off == 3'd0 ? DATA_WIDTH'({pre, 5'b0, ien, ar, en}) :
                off == 3'd1 ? DATA_WIDTH'(load) :
                off == 3'd2 ? DATA_WIDTH'(count) :
                off == 3'd3 ? DATA_WIDTH'(expired) :
                off == 3'd4 ? cap : '0;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         bus.ready     <= 1'b0;
         bus.read_data <= '0;
         en            <= 1'b0;
         ar            <= 1'b0;
         ien           <= 1'b0;
         pre           <= '0;
         pcnt          <= '0;
         load          <= '0;
         count         <= '0;
         expired       <= 1'b0;
         irq           <= 1'b0;
`ifdef TIMER_CAPTURE_EN
         csync         <= '0;
         capture       <= '0;
`endif
      end else begin
         state         <= acc ? RESP : IDLE;
         bus.ready     <= acc;
         // a simultaneous read+write is a write, so nothing is returned
         bus.read_data <= (acc & ~bus.write_enable) ? rmux : '0;
         en            <= en_n;
         ar            <= wr_ctrl ? bus.write_data[1] : ar;
         ien           <= ien_n;
         pre           <= wr_ctrl ? bus.write_data[15:8] : pre;
         pcnt          <= (!en || wr_load || tick) ? 8'd0 : pcnt + 8'd1;
         load          <= wr_load ? bus.write_data[COUNT_WIDTH-1:0] : load;
         count         <= wr_load ? bus.write_data[COUNT_WIDTH-1:0] :
                          !tick ? count :
                          count != '0 ? count - 1'b1 :
                          ar ? load : '0;
         expired       <= exp_n;
         irq           <= exp_n & ien_n;
`ifdef TIMER_CAPTURE_EN
         // two sync flops, third flop for edge detect; count here is the pre-update value
         csync         <= {csync[1:0], capture_in};
         capture       <= (csync[1] & ~csync[2]) ? count : capture;
`endif
      end
   end
endmodule

// File: tb/tb_mmio_timer_responder.sv
// tb_mmio_timer_responder: directed-vector bench for mmio_timer_responder
module tb_mmio_timer_responder;
   logic clock = 1'b0;
   logic reset_n;
   logic irq;
   logic capture_in;
   int   vectors = 0;
   int   errors = 0;
   mmio_timer_responder_if #(.DATA_WIDTH(64)) bus ();
   mmio_timer_responder dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus),
      .irq(irq)
`ifdef TIMER_CAPTURE_EN
      ,
      .capture_in(capture_in)
`endif
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // called at a negedge; returns at a negedge, two cycles per completed access
   task automatic access(input logic [31:0] a, input logic w, input logic r, input logic [63:0] wd,
                         output logic [63:0] rd, output int lat);
      bus.address = a;
      bus.write_enable = w;
      bus.read_enable = r;
      bus.write_data = wd;
      lat = 0;
      rd = '0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clock);
         if (bus.ready) begin
            lat = i;
            rd = bus.read_data;
            break;
         end
      end
      bus.write_enable = 1'b0;
      bus.read_enable = 1'b0;
      if (lat != 0) @(negedge clock);
   endtask
   task automatic wr(input logic [31:0] a, input logic [63:0] d);
      logic [63:0] x;
      int l;
      access(a, 1'b1, 1'b0, d, x, l);
      chk("write latency", 64'(l), 64'd1);
   endtask
   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [63:0] exp);
      logic [63:0] d;
      int l;
      access(a, 1'b0, 1'b1, '0, d, l);
      chk({tag, " latency"}, 64'(l), 64'd1);
      chk(tag, d, exp);
   endtask
   localparam logic [31:0] CTRL = 32'h20000000, LOAD = 32'h20000008, COUNT = 32'h20000010,
                           STAT = 32'h20000018, CAPT = 32'h20000020;
   initial begin
      logic [63:0] d;
      int l;
      reset_n = 1'b0;
      capture_in = 1'b0;
      bus.address = '0;
      bus.read_enable = 1'b0;
      bus.write_enable = 1'b0;
      bus.write_data = '0;
      repeat (2) @(negedge clock);
      chk("reset ready", 64'(bus.ready), 0);
      chk("reset read_data", bus.read_data, 0);
      chk("reset irq", 64'(irq), 0);
      reset_n = 1'b1;
      rd_chk("ctrl after reset", CTRL, 0);
      chk("irq after reset", 64'(irq), 0);
      // one-shot, prescale 0: count 3->2->1->0, expiry on the tick at 0
      wr(LOAD, 3);
      wr(CTRL, 64'h5);
      rd_chk("oneshot count a", COUNT, 2);
      rd_chk("oneshot count b", COUNT, 0);
      chk("oneshot irq", 64'(irq), 1);
      rd_chk("oneshot status", STAT, 1);
      rd_chk("oneshot ctrl", CTRL, 64'h4);
      rd_chk("oneshot count held", COUNT, 0);
      wr(STAT, 1);
      chk("irq after clear", 64'(irq), 0);
      rd_chk("status after clear", STAT, 0);
      // prescale 1: one tick every two cycles, aligned with the access rate
      wr(LOAD, 3);
      wr(CTRL, 64'h105);
      rd_chk("ps1 count 3", COUNT, 3);
      rd_chk("ps1 count 2", COUNT, 2);
      rd_chk("ps1 count 1", COUNT, 1);
      rd_chk("ps1 count 0", COUNT, 0);
      chk("ps1 irq", 64'(irq), 1);
      rd_chk("ps1 ctrl", CTRL, 64'h104);
      wr(STAT, 1);
      chk("ps1 irq cleared", 64'(irq), 0);
      // auto-reload, prescale 2, LOAD 1: tick every 3 cycles, expiry every 6
      wr(LOAD, 1);
      wr(CTRL, 64'h203);
      rd_chk("ar count a", COUNT, 1);
      rd_chk("ar count b", COUNT, 0);
      rd_chk("ar count c", COUNT, 0);
      rd_chk("ar count d", COUNT, 1);
      rd_chk("ar count e", COUNT, 0);
      wr(STAT, 1);
      rd_chk("ar clear vs set", STAT, 1);
      chk("ar irq disabled", 64'(irq), 0);
      wr(STAT, 1);
      rd_chk("ar cleared", STAT, 0);
      rd_chk("ar ctrl", CTRL, 64'h203);
      // decode corners
      rd_chk("unmapped read", 32'h20000038, 0);
      access(32'h20000040, 1'b0, 1'b1, '0, d, l);
      chk("outside window no ready", 64'(l), 0);
      access(LOAD, 1'b1, 1'b1, 64'h7, d, l);
      chk("rw both latency", 64'(l), 1);
      chk("rw both read_data", d, 0);
      rd_chk("load low bits ignored", 32'h2000000C, 7);
`ifdef TIMER_CAPTURE_EN
      wr(CTRL, 0);
      wr(LOAD, 5);
      capture_in = 1'b1;
      repeat (3) @(negedge clock);
      capture_in = 1'b0;
      repeat (3) @(negedge clock);
      rd_chk("capture", CAPT, 5);
`else
      rd_chk("capture absent", CAPT, 0);
`endif
      wr(CTRL, 64'h205);
      // reset right after a write is sampled aborts it
      bus.address = LOAD;
      bus.write_enable = 1'b1;
      bus.write_data = 64'h9;
      @(posedge clock);
      #1 reset_n = 1'b0;
      @(negedge clock);
      chk("abort ready", 64'(bus.ready), 0);
      bus.write_enable = 1'b0;
      @(negedge clock);
      chk("abort ready held", 64'(bus.ready), 0);
      reset_n = 1'b1;
      rd_chk("ctrl after abort", CTRL, 0);
      rd_chk("load after abort", LOAD, 0);
      rd_chk("count after abort", COUNT, 0);
      rd_chk("status after abort", STAT, 0);
      chk("irq after abort", 64'(irq), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/mmio_timer_responder.md
Name: mmio_timer_responder

Overview:
- Memory-mapped countdown timer: the responder side of the LEGv8 peripheral bus.
- Decodes its own base/mask window, accepts single read/write requests from the CPU data port, and returns a one-cycle `ready` pulse with read data.
- Drives a level interrupt to the interrupt controller when the count expires.

Parameters:
- BASE_ADDRESS, 32'h20000000, window base; must be aligned to the window size.
- ADDRESS_MASK, 32'hFFFFFFC0, address bits compared against BASE_ADDRESS (1 = compared); window is 64 bytes.
- DATA_WIDTH, 64, bus data width; register fields are zero-extended to it.
- COUNT_WIDTH, 32, width of LOAD, COUNT and CAPTURE.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  32  byte address of the request.
- read_enable  input  1  read request, held until `ready`.
- write_enable  input  1  write request, held until `ready`.
- write_data  input  DATA_WIDTH  write payload.
- read_data  output  DATA_WIDTH  read payload; valid only while `ready`=1, otherwise 0.
- ready  output  1  one-cycle completion pulse for a selected request.
- irq  output  1  timer interrupt, level.
- capture_in  input  1  external capture strobe; present only with TIMER_CAPTURE_EN.

Behaviour:
- Select: `sel = (read_enable | write_enable) & ((address & ADDRESS_MASK) == BASE_ADDRESS)`. No response when `sel` = 0.
- Register offsets use address[5:3]; address[2:0] is ignored.
  - 0x00 CTRL: [0] enable, [1] auto_reload, [2] irq_en, [15:8] prescale.
  - 0x08 LOAD.
  - 0x10 COUNT: read-only.
  - 0x18 STATUS: [0] expired, write-1-to-clear.
  - 0x20 CAPTURE: optional.
- Unmapped offsets: reads return 0, writes are ignored, `ready` is still pulsed.
- Handshake FSM, two states:
  - IDLE: on `sel`, perform the register write (if `write_enable`) or latch read data (if `read_enable`) at that edge, then go to RESP.
  - RESP: `ready`=1 for exactly one cycle, `read_data` driven, then go to IDLE.
  - The requester deasserts the request in the cycle after `ready`.
  - A request still asserted in the IDLE cycle after RESP starts a new access: back-to-back accesses take 2 cycles each.
- Latency: `ready` is asserted 1 cycle after the request is first sampled.
- If `read_enable` and `write_enable` are both 1, the access is treated as a write and `read_data` = 0.
- Prescaler:
  - Internal 8-bit `pcnt` counts 0..prescale while enable=1.
  - `tick` = (`pcnt` == prescale), after which `pcnt` wraps to 0.
  - prescale = 0 gives one tick per cycle.
  - `pcnt` is held at 0 while enable=0.
- Counter, on each `tick`:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: expired is set. If auto_reload, COUNT <= LOAD; otherwise COUNT stays 0 and enable is cleared by hardware.
- A LOAD write also writes COUNT and resets `pcnt` to 0. If it coincides with a `tick`, the write wins.
- A CTRL write that coincides with the hardware enable clear: the write wins.
- STATUS: writing 1 to bit 0 clears expired. If the clear coincides with a set, the set wins.
- irq = expired & irq_en, registered (asserted the cycle after the set).
- Reset values:
  - All registers 0, `pcnt` 0, FSM in IDLE.
  - Outputs: `ready` 0, `read_data` 0, `irq` 0.
  - Reset asserted mid-access aborts it with no `ready` pulse.

Optional Feature:
- Macro: TIMER_CAPTURE_EN.
- Defined:
  - The `capture_in` port exists, passed through a 2-flop synchronizer.
  - A rising edge of the synchronized signal latches the current COUNT into CAPTURE at offset 0x20.
  - If the capture coincides with a COUNT update, the pre-update value is captured.
- Undefined: there is no port, and offset 0x20 reads 0 like any unmapped offset.

Test Plan:
- Reset, then read CTRL at 0x20000000 → `ready` exactly 1 cycle later; `read_data` = 0; `irq` = 0.
- Write LOAD = 3, write CTRL = 0x5 (prescale 0, irq_en) → COUNT reads 3,2,1,0 on successive ticks; expired set and `irq` = 1 one cycle after the tick at COUNT = 0; CTRL.enable reads 0.
- CTRL = 0x0203 (auto_reload, prescale 2), LOAD = 1 → COUNT changes every 3 cycles as 1,0,1,0…; expired set; STATUS write 0x1 clears it unless it coincides with a set.
- Read 0x20000038 (unmapped) and 0x20000040 (outside window) → first: `ready` with `read_data` 0; second: no `ready` ever.
- Assert `reset_n`=0 in the cycle after a write request is sampled → no `ready` pulse; all registers read 0 after reset is released.
- With TIMER_CAPTURE_EN: pulse `capture_in` while COUNT = 5 → CAPTURE reads 5 (or the pre-tick value); without the macro, offset 0x20 reads 0.
